mc_datapath_mul: RTL and testbench

//  Parametrised successor of the multi-cycle ARM datapath. Contains PC/IR/Data/A/WD/ALUOut

---
 rtl/mc_datapath_mul.sv | 222 ++++++++++++++++++++++
 tb/tb_mc_datapath_mul.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_datapath_mul.sv
// mc_datapath_mul -- multi-cycle ARM datapath with a sequential shift-add multiplier.
//
// Holds the PC/IR/Data/A/WD/ALUOut registers, a 16-entry register file (R15 reads
// as Result, writes to R15 redirect to PC), the immediate extender, the ALU and the
// result mux. MUL is done by a radix-2 shift-add unit with a start/busy/done
// handshake so the controller can stall on it.
//
// Optional build macro: MC_MUL_EARLY_EXIT_EN -- the multiplier stops iterating as
// soon as the remaining multiplier bits are all zero.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-low reset
//   Adr, WriteData    memory address / store data (WD register)
//   ReadData          memory read data (feeds IR and Data)
//   Instr             instruction register
//   ALUFlags          {N,Z,C,V} of the current ALU result
//   opMul             selects the MUL register-field layout
//   PCWrite..ALUControl  controller enables and mux selects
//   MulStart          one-cycle multiply request (A * WD)
//   MulBusy, MulDone  multiplier iterating / one-cycle product-valid pulse
//   PC, Result        debug views of the program counter and result bus
module mc_datapath_mul #(
    parameter int              XLEN     = 32,
    parameter int              PC_STEP  = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] Adr,
    output logic [XLEN-1:0] WriteData,
    input  logic [XLEN-1:0] ReadData,
    output logic [31:0]     Instr,
    output logic [3:0]      ALUFlags,
    input  logic            opMul,
    input  logic            PCWrite,
    input  logic            RegWrite,
    input  logic            IRWrite,
    input  logic            AdrSrc,
    input  logic            ALUSrcA,
    input  logic [1:0]      RegSrc,
    input  logic [1:0]      ALUSrcB,
    input  logic [1:0]      ResultSrc,
    input  logic [1:0]      ImmSrc,
    input  logic [2:0]      ALUControl,
    input  logic            MulStart,
    output logic            MulBusy,
    output logic            MulDone,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] Result
);

    localparam int CW = $clog2(XLEN + 1);

    logic [XLEN-1:0] pc, data, a, wd, aluout;
    logic [31:0]     ir;
    logic [XLEN-1:0] rf [16];

    logic [3:0]      rn, rd, rm, ra1, ra2;
    logic [XLEN-1:0] rd1, rd2, extimm, srca, srcb, alures, product;

    // ---------------- register-field decode ----------------
    assign rn  = opMul ? ir[3:0]   : ir[19:16];
    assign rd  = opMul ? ir[19:16] : ir[15:12];
    assign rm  = opMul ? ir[11:8]  : ir[3:0];
    assign ra1 = RegSrc[0] ? 4'd15 : rn;
    assign ra2 = RegSrc[1] ? rd    : rm;

    // R15 is not stored; reading it yields the result bus (PC+8 from the controller).
    assign rd1 = (ra1 == 4'd15) ? Result : rf[ra1];
    assign rd2 = (ra2 == 4'd15) ? Result : rf[ra2];

    // ---------------- extender ----------------
    always_comb begin
        extimm = '0;
        case (ImmSrc)
            2'd0:    extimm = {{(XLEN-8){1'b0}}, ir[7:0]};
            2'd1:    extimm = {{(XLEN-12){1'b0}}, ir[11:0]};
            2'd2:    extimm = {{(XLEN-26){ir[23]}}, ir[23:0], 2'b00};
            default: extimm = '0;
        endcase
    end

    // ---------------- ALU ----------------
    assign srca = ALUSrcA ? pc : a;
    always_comb begin
        srcb = '0;
        case (ALUSrcB)
            2'd0:    srcb = wd;
            2'd1:    srcb = extimm;
            2'd2:    srcb = XLEN'(PC_STEP);
            default: srcb = '0;
        endcase
    end

    logic            is_sub, cflag, vflag;
    logic [XLEN-1:0] b_eff;
    logic [XLEN:0]   sum;

    // Subtraction is a + ~b + 1, so the carry out is already NOT-borrow.
    assign is_sub = (ALUControl == 3'b001);
    assign b_eff  = is_sub ? ~srcb : srcb;
    assign sum    = {1'b0, srca} + {1'b0, b_eff} + {{XLEN{1'b0}}, is_sub};

    always_comb begin
        alures = '0;
        cflag  = 1'b0;
        vflag  = 1'b0;
        case (ALUControl)
            3'b000, 3'b001: begin
                alures = sum[XLEN-1:0];
                cflag  = sum[XLEN];
                vflag  = (srca[XLEN-1] == b_eff[XLEN-1]) &&
                         (sum[XLEN-1] != srca[XLEN-1]);
            end
            3'b010:  alures = srca & srcb;
            3'b011:  alures = srca | srcb;
            3'b100:  alures = srca ^ srcb;
            default: alures = '0;
        endcase
    end

    assign ALUFlags = {alures[XLEN-1], (alures == '0), cflag, vflag};

    // ---------------- result mux / outputs ----------------
    always_comb begin
        Result = aluout;
        case (ResultSrc)
            2'd0: Result = aluout;
            2'd1: Result = data;
            2'd2: Result = alures;
            2'd3: Result = product;
        endcase
    end

    assign Adr       = AdrSrc ? Result : pc;
    assign WriteData = wd;
    assign Instr     = ir;
    assign PC        = pc;

    // ---------------- architectural registers ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc     <= RESET_PC;
            ir     <= '0;
            data   <= '0;
            a      <= '0;
            wd     <= '0;
            aluout <= '0;
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else begin
            if (PCWrite || (RegWrite && rd == 4'd15)) pc <= Result;
            if (IRWrite) ir <= ReadData[31:0];
            data   <= ReadData;
            a      <= rd1;
            wd     <= rd2;
            aluout <= alures;
            if (RegWrite && rd != 4'd15) rf[rd] <= Result;
        end
    end

    // ---------------- shift-add multiplier ----------------
    typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mstate_t;
    mstate_t mstate, mstate_nxt;

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] mcand, mplier, acc, acc_nxt, mplier_sh;
    logic            run_last, accept;

    assign acc_nxt   = mplier[0] ? acc + mcand : acc;
    assign mplier_sh = mplier >> 1;
    // A request in the DONE cycle is taken, giving back-to-back multiplies.
    assign accept    = MulStart && (mstate != M_RUN);

`ifdef MC_MUL_EARLY_EXIT_EN
    assign run_last = (cnt == CW'(1)) || (mplier_sh == '0);
`else
    assign run_last = (cnt == CW'(1));
`endif

    always_ff @(posedge clk) begin
        if (!reset) mstate <= M_IDLE;
        else        mstate <= mstate_nxt;
    end

    always_comb begin
        mstate_nxt = mstate;
        case (mstate)
            M_IDLE:  mstate_nxt = accept ? M_RUN : M_IDLE;
            M_RUN:   mstate_nxt = run_last ? M_DONE : M_RUN;
            M_DONE:  mstate_nxt = accept ? M_RUN : M_IDLE;
            default: mstate_nxt = M_IDLE;
        endcase
    end

    always_comb begin
        MulBusy = (mstate == M_RUN);
        MulDone = (mstate == M_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            mcand  <= a;
            mplier <= wd;
            acc    <= '0;
            cnt    <= CW'(XLEN);
        end else if (mstate == M_RUN) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier_sh;
            cnt    <= cnt - CW'(1);
            // Product is published as the FSM enters DONE and held afterwards.
            if (run_last) product <= acc_nxt;
        end
    end

endmodule

// File: tb/tb_mc_datapath_mul.sv
module tb_mc_datapath_mul;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] Adr, WriteData, ReadData, PC, Result;
    logic [31:0]     Instr;
    logic [3:0]      ALUFlags;
    logic            opMul, PCWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0]      RegSrc, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]      ALUControl;
    logic            MulStart, MulBusy, MulDone;

    int unsigned checks = 0, failures = 0, cyc = 0;

    typedef struct {
        logic [31:0] prod;
        int unsigned at;
    } exp_t;
    exp_t q[$];

    mc_datapath_mul #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData), .ReadData(ReadData),
        .Instr(Instr), .ALUFlags(ALUFlags), .opMul(opMul), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .RegSrc(RegSrc), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .MulStart(MulStart), .MulBusy(MulBusy),
        .MulDone(MulDone), .PC(PC), .Result(Result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------- reference models ----------
    function automatic int unsigned mul_lat(input logic [31:0] y);
`ifdef MC_MUL_EARLY_EXIT_EN
        int unsigned hb = 0;
        for (int i = 0; i < 32; i++) if (y[i]) hb = i + 1;
        return 1 + ((hb < 1) ? 1 : hb);
`else
        return XLEN + 1;
`endif
    endfunction

    function automatic logic [35:0] alu_ref(input logic [2:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
        longint      sx = longint'($signed(x));
        longint      sy = longint'($signed(y));
        longint      s;
        logic [31:0] r = 0;
        logic        c = 0, v = 0;
        case (op)
            3'd0: begin
                r = x + y; s = sx + sy;
                c = ({32'h0, x} + {32'h0, y}) > 64'hFFFF_FFFF;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                r = x - y; s = sx - sy;
                c = (x >= y);
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            default: r = 0;
        endcase
        return {r[31], (r == 0), c, v, r};
    endfunction

    function automatic logic [31:0] ext_ref(input logic [1:0] m, input logic [31:0] ins);
        longint v;
        case (m)
            2'd0: v = ins % 256;
            2'd1: v = ins % 4096;
            2'd2: begin
                v = longint'(ins[23:0]) * 4;
                if (ins[23]) v = v - (64'sd1 << 26);
            end
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    // ---------- monitor / scoreboard ----------
    always @(negedge clk) begin
        if (MulDone) begin
            if (q.size() == 0) begin
                checks++; failures++;
                $display("FAIL mul_unexpected_done: MulDone=1 with nothing expected (cyc %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("mul_product", Result, e.prod);
                chk("mul_latency", cyc, e.at);
            end
        end
    end

    // ---------- stimulus helpers ----------
    task automatic tick(); @(negedge clk); endtask

    task automatic load_ir(input logic [31:0] v);
        ReadData = v; IRWrite = 1; tick(); IRWrite = 0;
    endtask

    task automatic write_reg(input logic [3:0] r, input logic [31:0] v);
        opMul = 0; RegSrc = 0; RegWrite = 0;
        load_ir({16'h0, r, 12'h0});
        ReadData = v; tick();
        ResultSrc = 1; RegWrite = 1; tick(); RegWrite = 0;
    endtask

    task automatic setup_mul(input logic [31:0] x, input logic [31:0] y);
        write_reg(2, x); write_reg(3, y);
        load_ir(32'h0004_0302);   // Rd=4, Rm(mplier)=R3, Rn(mcand)=R2 in MUL layout
        opMul = 1; ResultSrc = 3; tick();
    endtask

    task automatic start_mul(input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        e.prod = x * y; e.at = cyc + mul_lat(y);
        q.push_back(e);
        MulStart = 1; tick(); MulStart = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && q.size() != 0; i++) tick();
        if (q.size() != 0) begin
            checks++; failures++;
            $display("FAIL mul_timeout: %0d products outstanding", q.size());
            q.delete();
        end
    endtask

    task automatic alu_setup(input logic [31:0] x, input logic [31:0] y);
        write_reg(1, x); write_reg(2, y);
        load_ir(32'h0001_0002);   // Rn=R1, Rm=R2
        tick();
        ALUSrcA = 0; ALUSrcB = 0; ResultSrc = 2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] x, y, ins;
        logic [35:0] r;
        logic [2:0]  op;
        logic [31:0] pc_m;
        reset = 0; ReadData = 0; opMul = 0; PCWrite = 0; RegWrite = 0; IRWrite = 0;
        AdrSrc = 0; ALUSrcA = 0; RegSrc = 0; ALUSrcB = 0; ResultSrc = 0; ImmSrc = 0;
        ALUControl = 0; MulStart = 0;

        // reset state and PC stepping
        tick(); tick();
        chk("rst_pc", PC, 0);
        chk("rst_busy", {31'h0, MulBusy}, 0);
        chk("rst_done", {31'h0, MulDone}, 0);
        chk("rst_instr", Instr, 0);
        reset = 1; ALUSrcA = 1; ALUSrcB = 2; ResultSrc = 2; PCWrite = 1;
        #1;
        chk("pc_step0", PC, 0);
        chk("adr_is_pc", Adr, 0);
        chk("result_pc4", Result, 4);
        tick(); chk("pc_step1", PC, 4);
        tick(); chk("pc_step2", PC, 8);
        PCWrite = 0; pc_m = 8;

        // directed ALU corners
        alu_setup(5, 5); ALUControl = 1; #1;
        chk("sub_res", Result, 0);
        chk("sub_flags", {28'h0, ALUFlags}, 4'b0110);
        alu_setup(32'h7FFF_FFFF, 1); ALUControl = 0; #1;
        chk("add_res", Result, 32'h8000_0000);
        chk("add_flags", {28'h0, ALUFlags}, 4'b1001);
        alu_setup(32'h8000_0000, 1); ALUControl = 1; #1;
        r = alu_ref(1, 32'h8000_0000, 1);
        chk("sub_ovf_flags", {28'h0, ALUFlags}, {28'h0, r[35:32]});

        // random ALU operations
        for (int i = 0; i < 10; i++) begin
            x = $urandom; y = (i % 3 == 0) ? x : $urandom;
            op = 3'($urandom_range(0, 7));
            alu_setup(x, y); ALUControl = op; #1;
            r = alu_ref(op, x, y);
            chk("alu_rand_res", Result, r[31:0]);
            chk("alu_rand_flags", {28'h0, ALUFlags}, {28'h0, r[35:32]});
        end

        // extender through PC + ExtImm
        for (int i = 0; i < 8; i++) begin
            ins = $urandom;
            load_ir(ins);
            ALUSrcA = 1; ALUSrcB = 1; ALUControl = 0; ResultSrc = 2;
            ImmSrc = 2'(i % 4); #1;
            chk("ext_rand", Result, pc_m + ext_ref(ImmSrc, ins));
        end
        ImmSrc = 0;

        // 7*6, then write product to R4 and read it back
        setup_mul(7, 6); start_mul(7, 6);
        chk("busy_run", {31'h0, MulBusy}, 1);
        wait_idle();
        RegWrite = 1; tick(); RegWrite = 0;
        opMul = 0; load_ir(32'h0004_0000); tick();
        ALUSrcA = 0; ALUSrcB = 2; ALUControl = 0; ResultSrc = 2; #1;
        chk("r4_readback", Result, 42 + 4);

        // truncation, with an ignored start in mid-run
        setup_mul(32'hFFFF_FFFF, 2); start_mul(32'hFFFF_FFFF, 2);
        repeat (4) tick();
        MulStart = 1; tick(); MulStart = 0;
        wait_idle();

        // back-to-back: start accepted in the DONE cycle
        x = $urandom; y = $urandom | 32'h8000_0000;
        setup_mul(x, y); start_mul(x, y);
        for (int i = 0; i < 100 && !MulDone; i++) tick();
        start_mul(x, y);
        wait_idle();

        // random products with varying multiplier width
        for (int i = 0; i < 6; i++) begin
            x = $urandom; y = $urandom >> $urandom_range(0, 31);
            setup_mul(x, y); start_mul(x, y);
            wait_idle();
        end

`ifdef MC_MUL_EARLY_EXIT_EN
        setup_mul(9, 3); start_mul(9, 3); wait_idle();
        setup_mul(32'h1234_5678, 0); start_mul(32'h1234_5678, 0); wait_idle();
`endif

        // reset in mid-multiply aborts it
        setup_mul(32'h1234, 32'h5678); start_mul(32'h1234, 32'h5678); wait_idle();
        setup_mul(3, 32'h8000_0005);
        MulStart = 1; tick(); MulStart = 0;
        repeat (9) tick();
        reset = 0; tick(); #1;
        chk("abort_busy", {31'h0, MulBusy}, 0);
        chk("abort_done", {31'h0, MulDone}, 0);
        chk("abort_product", Result, 0);
        chk("abort_pc", PC, 0);
        reset = 1;
        repeat (40) tick();
        chk("queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
